// File: rtl/uart_boot_loader_pkg.sv
// Shared UART boot-loader types: FSM states, command codes, checksum.
// Imported by the byte-edge detector and the loader top.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DHI,
    ST_DLO,
    ST_CKSUM,
    ST_WRITE
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_END   = 8'h02;
  localparam logic [8:0] WC_MAX    = 9'h1FF;

  function automatic logic [7:0] cksum8(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    return 8'(a + b + c);
  endfunction

endpackage

// File: rtl/uart_boot_loader_rx_edge.sv
// Turns the UART receiver's level done flag into a one-cycle byte event.
// A flag held high yields exactly one event.
module uart_rx_edge
  import uart_boot_loader_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_rx_done,
  output logic o_byte_evt
);

  logic r_rx_done;

  always_ff @(posedge clk) begin
    if (!reset) r_rx_done <= 1'b0;
    else        r_rx_done <= i_rx_done;
  end

  assign o_byte_evt = i_rx_done & ~r_rx_done;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial boot loader: parses SYNC/CMD frames from the UART and writes
// 16-bit instruction words into program memory while holding the CPU.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rx_done,
  input  logic [7:0]  i_rx_data,
  output logic        o_mem_we,
  output logic [7:0]  o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_cpu_hold,
  output logic        o_load_done,
  output logic        o_err_cksum,
  output logic        o_err_timeout,
  output logic [8:0]  o_word_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_addr;
  logic [7:0]    r_dhi;
  logic [7:0]    r_dlo;
  logic          r_mem_we;
  logic [7:0]    r_mem_addr;
  logic [15:0]   r_mem_wdata;
  logic          r_cpu_hold;
  logic          r_load_done;
  logic          r_err_cksum;
  logic          r_err_tmo;
  logic [8:0]    r_wc;

  logic w_evt;
  logic w_active;
  logic w_tmo_hit;

  uart_rx_edge u_rx_edge (
    .clk        (clk),
    .reset      (reset),
    .i_rx_done  (i_rx_done),
    .o_byte_evt (w_evt)
  );

  assign w_active  = (r_state != ST_IDLE) && (r_state != ST_WRITE);
  assign w_tmo_hit = w_active && !w_evt && (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_tmo       <= '0;
      r_addr      <= '0;
      r_dhi       <= '0;
      r_dlo       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_err_cksum <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_wc        <= '0;
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      r_err_cksum <= 1'b0;
      r_err_tmo   <= 1'b0;

      // Timer only runs while a frame is open
      if (!w_active || w_evt)    r_tmo <= '0;
      else if (r_tmo != TMO_LAST) r_tmo <= r_tmo + 1'b1;

      if (w_tmo_hit) begin
        r_state   <= ST_IDLE;
        r_err_tmo <= 1'b1;
      end else begin
        unique case (r_state)
          ST_IDLE, ST_WRITE: begin
            if (w_evt && i_rx_data == SYNC_BYTE) r_state <= ST_CMD;
            else                                 r_state <= ST_IDLE;
          end
          ST_CMD: if (w_evt) begin
            if (i_rx_data == CMD_WRITE) begin
              r_state <= ST_ADDR;
            end else if (i_rx_data == CMD_END) begin
              r_state     <= ST_IDLE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
            end else begin
              r_state   <= ST_IDLE;
              r_err_tmo <= 1'b1;
            end
          end
          ST_ADDR: if (w_evt) begin
            r_addr  <= i_rx_data;
            r_state <= ST_DHI;
          end
          ST_DHI: if (w_evt) begin
            r_dhi   <= i_rx_data;
            r_state <= ST_DLO;
          end
          ST_DLO: if (w_evt) begin
            r_dlo   <= i_rx_data;
            r_state <= ST_CKSUM;
          end
          ST_CKSUM: if (w_evt) begin
            if (cksum8(r_addr, r_dhi, r_dlo) == i_rx_data) begin
              r_state     <= ST_WRITE;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= {r_dhi, r_dlo};
              if (r_wc != WC_MAX) r_wc <= r_wc + 1'b1;
            end else begin
              r_state     <= ST_IDLE;
              r_err_cksum <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_mem_we      = r_mem_we;
  assign o_mem_addr    = r_mem_addr;
  assign o_mem_wdata   = r_mem_wdata;
  assign o_cpu_hold    = r_cpu_hold;
  assign o_load_done   = r_load_done;
  assign o_err_cksum   = r_err_cksum;
  assign o_err_timeout = r_err_tmo;
  assign o_word_count  = r_wc;

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, maximum clk cycles allowed between bytes inside a frame.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 i_rx_done  input  1  receive-complete flag from the UART receiver (level; a rising edge marks a new byte).
REQ-006 i_rx_data  input  8  received byte; valid in the cycle i_rx_done rises.
REQ-007 o_mem_we  output  1  one-cycle program-memory write strobe.
REQ-008 o_mem_addr  output  8  program-memory word address.
REQ-009 o_mem_wdata  output  16  instruction word to write.
REQ-010 o_cpu_hold  output  1  holds the CPU in reset/stall while loading.
REQ-011 o_load_done  output  1  one-cycle pulse when the END command is accepted.
REQ-012 o_err_cksum  output  1  one-cycle pulse on checksum mismatch.
REQ-013 o_err_timeout  output  1  one-cycle pulse on inter-byte timeout or bad command.
REQ-014 o_word_count  output  9  number of words successfully written since reset.

Function
REQ-015 Byte event: i_rx_done high in cycle N and low in cycle N-1 (registered copy); exactly one byte is consumed per rising edge, and a level held high produces no further events.
REQ-016 Frame format: SYNC_BYTE, CMD, then for CMD=8'h01: ADDR, DHI, DLO, CKSUM; for CMD=8'h02: no further bytes.
REQ-017 Checksum: CKSUM == (ADDR + DHI + DLO) mod 256 (8-bit wrap).
REQ-018 FSM states: IDLE, CMD, ADDR, DHI, DLO, CKSUM, WRITE.
REQ-019 IDLE: a byte equal to SYNC_BYTE -> CMD; any other byte is discarded and the FSM stays in IDLE.
REQ-020 CMD: 8'h01 -> ADDR; 8'h02 -> IDLE with o_load_done pulse and o_cpu_hold cleared in the next cycle; any other value -> IDLE with o_err_timeout pulse.
REQ-021 ADDR/DHI/DLO: latch the byte and advance to the next state.
REQ-022 CKSUM: on match -> WRITE; on mismatch -> IDLE with o_err_cksum pulse, no write, and o_word_count unchanged.
REQ-023 WRITE: o_mem_we high for exactly one cycle with o_mem_addr=ADDR and o_mem_wdata={DHI,DLO}; o_word_count increments; -> IDLE.
REQ-024 Latency: write strobe appears one cycle after the CKSUM byte event cycle.
REQ-025 o_mem_addr/o_mem_wdata hold their last values when o_mem_we is low.
REQ-026 Timeout counter clears on every byte event; in any state other than IDLE/WRITE, reaching TIMEOUT_CYCLES -> o_err_timeout pulse, return to IDLE, and discard the partial frame.
REQ-027 Timeout counter saturates and does not run in IDLE.
REQ-028 o_word_count saturates at 9'h1FF.
REQ-029 Once cleared, o_cpu_hold stays low until reset; later frames are still processed (live patching).
REQ-030 A SYNC_BYTE value received mid-frame is treated as ordinary data (no resync).
REQ-031 At most one of o_mem_we, o_load_done, o_err_cksum, o_err_timeout is high in any cycle.

Reset
REQ-032 When reset is low at a clk edge: FSM=IDLE, o_cpu_hold=1, all pulse outputs=0, o_mem_addr=0, o_mem_wdata=0, o_word_count=0, timeout counter=0, registered i_rx_done=0.
REQ-033 Reset mid-frame aborts the frame with no write and no error pulse.

Structure
REQ-034 State encodings and command codes (CMD_WRITE=8'h01, CMD_END=8'h02) are defined in the shared UART package.
REQ-035 One sub-module, uart_rx_edge, produces the one-cycle byte-event pulse; the FSM, datapath and timeout logic stay in uart_boot_loader.

Verification
REQ-036 Stimulus A5 01 10 12 34 56 -> one o_mem_we with addr 8'h10 and wdata 16'h1234; o_word_count=1; o_cpu_hold stays 1.
REQ-037 Stimulus A5 01 10 12 34 57 -> o_err_cksum pulse, no o_mem_we, o_word_count=0.
REQ-038 Stimulus 00 A5 02 -> leading byte ignored; o_load_done pulse; o_cpu_hold=0 from the following cycle.
REQ-039 Stimulus A5 01 10, then idle for TIMEOUT_CYCLES (param set to 50) -> o_err_timeout pulse; a following full valid frame then writes correctly.
REQ-040 Stimulus A5 07 -> o_err_timeout pulse, FSM back in IDLE; i_rx_done held high for 10 cycles -> only one byte consumed.
REQ-041 Stimulus: reset asserted after DHI of a valid frame -> no write, all outputs at their reset values.
